// File: rtl/nn_pkg.sv
// Shared neuron definitions: default Q-format widths, FSM state type and the
// rescale/saturate helper that the layer controller also uses.
package nn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 13;
  localparam int SAT_W      = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } neuron_state_t;

  // Drop frac_w fraction bits (floor toward -inf), then clamp to the signed data_w range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac_w,
    input int                      data_w
  );
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    r  = acc >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Stream/control bundle between the layer controller (master) and one neuron (slave).
interface neuron_mac_if #(
  parameter int DATA_W = nn_pkg::DATA_W_DEF
);
  logic                     Start;
  logic signed [DATA_W-1:0] Bias;
  logic                     Relu_En;
  logic                     In_Valid;
  logic                     In_Ready;
  logic signed [DATA_W-1:0] X;
  logic signed [DATA_W-1:0] W;
  logic                     Busy;
  logic                     Out_Valid;
  logic signed [DATA_W-1:0] Z;

  modport master (
    output Start, Bias, Relu_En, In_Valid, X, W,
    input  In_Ready, Busy, Out_Valid, Z
  );

  modport slave (
    input  Start, Bias, Relu_En, In_Valid, X, W,
    output In_Ready, Busy, Out_Valid, Z
  );
endinterface

// File: rtl/neuron_mac_sat.sv
// Combinational output stage: rescale the accumulator to Q(FRAC_W) in DATA_W,
// saturate, then optionally clamp negatives to zero.
module neuron_mac_sat
  import nn_pkg::*;
#(
  parameter int ACC_W  = 45,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic                     relu_en,
  output logic signed [DATA_W-1:0] z
);

  logic signed [DATA_W-1:0] rescaled;

  assign rescaled = DATA_W'(sat_shift(SAT_W'(acc), FRAC_W, DATA_W));

  // ReLU applied after saturation so a saturated-low result still maps to zero.
  always_comb begin
    z = rescaled;
    if (relu_en && rescaled[DATA_W-1]) z = '0;
  end

endmodule

// File: rtl/neuron_mac.sv
// Fixed-point neuron: accumulates N_INPUTS signed X*W products onto a shifted
// bias, then emits one rescaled/saturated (optionally ReLU'd) activation.
//
//  state  | meaning
//  IDLE   | waiting for Start; Bias and Relu_En captured on Start
//  ACCUM  | In_Ready high, one product added per accepted pair
//  FINISH | Out_Valid pulse, Z already holds the new activation
module neuron_mac
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 784,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF
) (
  input logic         Clk,
  input logic         Reset,
  neuron_mac_if.slave bus
);

  // Wide enough for N_INPUTS worst-case products plus the shifted bias.
  localparam int ACC_W = 2 * DATA_W + $clog2(N_INPUTS) + 1;
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  neuron_state_t state, state_next;

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    bias_acc;
  logic signed [2*DATA_W-1:0] prod;
  logic [CNT_W-1:0]           count;
  logic                       relu_q;
  logic                       xfer;
  logic                       last;
  logic signed [DATA_W-1:0]   z_new;
  logic signed [DATA_W-1:0]   z_q;
  logic                       out_valid_q;

  assign prod     = bus.X * bus.W;
  assign acc_next = acc + ACC_W'(prod);
  assign bias_acc = ACC_W'(bus.Bias) <<< FRAC_W;
  assign xfer     = bus.In_Valid && (state == ACCUM);
  assign last     = xfer && (count == CNT_W'(N_INPUTS - 1));

  // Result is taken from acc_next so Z is already valid in the FINISH cycle.
  neuron_mac_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_sat (
    .acc     (acc_next),
    .relu_en (relu_q),
    .z       (z_new)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Start) state_next = ACCUM;
      ACCUM:   if (last)      state_next = FINISH;
      FINISH:                 state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake/status outputs decoded from state.
  always_comb begin
    bus.In_Ready = 1'b0;
    bus.Busy     = 1'b0;
    case (state)
      ACCUM: begin
        bus.In_Ready = 1'b1;
        bus.Busy     = 1'b1;
      end
      FINISH: bus.Busy = 1'b1;
      default: ;
    endcase
  end

  // Accumulator, pair counter and captured ReLU enable.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc    <= '0;
      count  <= '0;
      relu_q <= 1'b0;
    end else if (state == IDLE && bus.Start) begin
      acc    <= bias_acc;
      count  <= '0;
      relu_q <= bus.Relu_En;
    end else if (xfer) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

  // Output register: Z and the Out_Valid pulse both load on the final transfer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      z_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= last;
      if (last) z_q <= z_new;
    end
  end

  assign bus.Z         = z_q;
  assign bus.Out_Valid = out_valid_q;

endmodule
